gcd_unit: RTL
=============

GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (legal range 2..32).
REQ-002 Port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: go_i  input  1  start request; sampled only in IDLE.
REQ-005 Port: x_i  input  WIDTH  first operand, unsigned.
REQ-006 Port: y_i  input  WIDTH  second operand, unsigned.
REQ-007 Port: d_o  output  WIDTH  registered result; holds last result until the next completion.
REQ-008 Port: done_o  output  1  one-cycle completion pulse; d_o and err_o valid while high.
REQ-009 Port: busy_o  output  1  high in CALC and DONE.
REQ-010 Port: err_o  output  1  high when last operation had both operands zero; held like d_o.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-012 IDLE with go_i=1 at an edge: capture x_i into x_r and y_i into y_r, go to CALC.
REQ-013 IDLE with go_i=0: remain in IDLE; x_r, y_r, d_o and err_o unchanged.
REQ-014 CALC, either x_r or y_r zero: d_o <= x_r | y_r, err_o <= (both zero), go to DONE.
REQ-015 CALC, x_r == y_r (nonzero): d_o <= x_r, err_o <= 0, go to DONE.
REQ-016 CALC, x_r > y_r: x_r <= x_r - y_r, stay in CALC.
REQ-017 CALC, x_r < y_r: y_r <= y_r - x_r, stay in CALC.
REQ-018 Exactly one subtraction per CALC cycle; results never exceed WIDTH bits, and subtraction never underflows.
REQ-019 DONE: done_o = 1 for exactly that cycle; next state IDLE unconditionally.
REQ-020 Latency: with N subtractions required, done_o is high in the cycle after edge N+1 following the capture edge.
REQ-021 go_i while busy_o=1 SHALL be ignored; no queuing, no restart.
REQ-022 go_i held high continuously: a new capture occurs on the first IDLE edge after DONE (back-to-back operations, one idle cycle between).
REQ-023 x_i and y_i SHALL be don't-care except at the capture edge.
REQ-024 busy_o and done_o SHALL be decoded from registered state only (glitch-free, no combinational path from inputs).

Reset
REQ-025 RST_N low SHALL asynchronously force: state IDLE, x_r=0, y_r=0, d_o=0, done_o=0, busy_o=0, err_o=0.
REQ-026 Reset asserted mid-CALC SHALL abort the operation; no done_o pulse follows.
REQ-027 After RST_N deasserts, the first rising edge with go_i=1 SHALL start a new operation.

Configuration
REQ-028 Macro GCD_ITER_COUNT_EN, when defined, adds output port iter_o  output  WIDTH: count of subtraction cycles in the last operation.
REQ-029 With GCD_ITER_COUNT_EN defined: the counter clears at capture, increments on each subtracting CALC cycle and saturates at all-ones. iter_o is updated alongside d_o, is held until the next completion and resets to 0.
REQ-030 Without GCD_ITER_COUNT_EN: iter_o port and counter logic are absent; all other behaviour is identical.

Verification
REQ-031 WIDTH=8, x=12, y=8, go pulse -> two subtracting CALC cycles; done_o high on the 4th cycle after capture; d_o=4, err_o=0, iter_o=2.
REQ-032 x=0, y=9 -> done_o two cycles after capture, d_o=9, err_o=0; then x=0, y=0 -> d_o=0, err_o=1.
REQ-033 x=255, y=1 -> d_o=1, iter_o=254, busy_o high for 256 cycles.
REQ-034 x=7, y=7 -> d_o=7 with zero subtractions; a go_i pulse with x=100, y=50 during CALC -> ignored, result still 7.
REQ-035 x=200, y=150, RST_N low for 1 cycle mid-CALC -> all outputs 0 immediately, no done_o; next go with x=9, y=6 -> d_o=3.
REQ-036 go_i held high, alternating operands (18,12) and (35,14) -> consecutive done_o pulses with d_o=6 then 7, one IDLE cycle between operations.

Source files
------------

// File: rtl/gcd_unit.sv
// Iterative subtractive GCD engine: one subtraction per cycle, registered result and error flag.
// Optional build macro GCD_ITER_COUNT_EN adds iter_o, the subtraction count of the last operation.
//
// state  | meaning
// IDLE   | waiting for go_i; operands captured on the go edge
// CALC   | one subtraction per cycle until an operand is zero or both are equal
// DONE   | one-cycle completion pulse, then back to IDLE
module gcd_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             go_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] d_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             err_o
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_o
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] diff_xy;
  logic [WIDTH-1:0] diff_yx;
  logic             x_zero;
  logic             y_zero;
  logic             x_eq_y;
  logic             x_gt_y;
  logic             in_idle;
  logic             in_calc;
  logic             capture;
  logic             finish;
  logic             sub_x;
  logic             sub_y;

  assign in_idle = (state == S_IDLE);
  assign in_calc = (state == S_CALC);

  assign x_zero  = (x_r == '0);
  assign y_zero  = (y_r == '0);
  assign x_eq_y  = (x_r == y_r);
  assign x_gt_y  = (x_r > y_r);
  assign diff_xy = x_r - y_r;
  assign diff_yx = y_r - x_r;

  // Subtract only the smaller from the larger, so the difference can never wrap.
  assign capture = in_idle & go_i;
  assign finish  = in_calc & (x_zero | y_zero | x_eq_y);
  assign sub_x   = in_calc & ~finish & x_gt_y;
  assign sub_y   = in_calc & ~finish & ~x_gt_y;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go_i) state_nxt = S_CALC;
      S_CALC:  if (finish) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_r <= '0;
      y_r <= '0;
    end else if (capture) begin
      x_r <= x_i;
      y_r <= y_i;
    end else if (sub_x) begin
      x_r <= diff_xy;
    end else if (sub_y) begin
      y_r <= diff_yx;
    end
  end

  // When one operand is zero the OR is simply the other operand (or zero if both are).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d_o   <= '0;
      err_o <= 1'b0;
    end else if (finish) begin
      if (x_zero | y_zero) begin
        d_o   <= x_r | y_r;
        err_o <= x_zero & y_zero;
      end else begin
        d_o   <= x_r;
        err_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state == S_CALC) | (state == S_DONE);
  assign done_o = (state == S_DONE);

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      iter_cnt <= '0;
    end else if (capture) begin
      iter_cnt <= '0;
    end else if ((sub_x | sub_y) && (iter_cnt != '1)) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      iter_o <= '0;
    end else if (finish) begin
      iter_o <= iter_cnt;
    end
  end
`endif

endmodule
